// File: rtl/if_id_buf_pkg.sv
// Shared widths, constants and occupancy encoding for the IF/ID instruction buffer.
`timescale 1ns/1ps
package if_id_buf_pkg;

  // These mirror the core-wide XLEN, inst_len and NOP definitions.
  localparam int XLEN     = 32;
  localparam int INST_LEN = 32;
  localparam logic [INST_LEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0]  DEFAULT_RST_PC = 32'h8000_0000;

  // Occupancy view of the buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Map an occupancy count onto its derived state.
  function automatic occ_e occ_state(input int unsigned count, input int unsigned depth);
    if (count == 0)
      return OCC_EMPTY;
    else if (count >= depth)
      return OCC_FULL;
    else
      return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: a small circular FIFO of {pc, instr} pairs between
// fetch and decode. in_ready depends only on registered occupancy, so there is
// no combinational path from decode back-pressure to the PC register stall.
`timescale 1ns/1ps
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int              DEPTH  = 2,
  parameter logic [XLEN-1:0] RST_PC = DEFAULT_RST_PC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [INST_LEN-1:0]        in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [INST_LEN-1:0]        out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage is deliberately not reset; occupancy alone decides validity.
  logic [XLEN-1:0]     pc_mem    [DEPTH];
  logic [INST_LEN-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;
  occ_e occ;

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count_o   = count;
  assign occ       = occ_state(int'(count), DEPTH);

  // Head entry is read straight from registered storage; empty shows reset PC and NOP.
  always_comb begin
    out_pc    = RST_PC;
    out_instr = NOP;
    if (occ != OCC_EMPTY) begin
      out_pc    = pc_mem[head];
      out_instr = instr_mem[head];
    end
  end

  // Write the incoming pair at the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end

  // Pointer and occupancy control; flush drops everything including same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (pop)
        head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: reset, fill, full-with-pop, streaming wrap,
// flush with incoming pair, hold under back-pressure and asynchronous reset.
`timescale 1ns/1ps
module tb_if_id_buf;

  localparam logic [31:0] RST_PC_V = 32'h8000_0000;
  localparam logic [31:0] NOP_V    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [1:0]  count_o;

  int tests_run;
  int tests_failed;

  logic [31:0] q_pc    [$];
  logic [31:0] q_instr [$];

  if_id_buf #(.DEPTH(2), .RST_PC(RST_PC_V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset held for three cycles, then idle.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_instr", out_instr, NOP_V);
    check("rst_out_pc",    out_pc,    RST_PC_V);
    check("rst_count",     count_o,   0);
    rst_n = 1'b1;

    // Fill with two entries while decode stalls; no same-cycle bypass.
    in_valid = 1'b1; in_pc = 32'h8000_0000; in_instr = 32'h0010_0093;
    #1;
    check("no_bypass_valid", out_valid, 0);
    check("no_bypass_pc",    out_pc,    RST_PC_V);
    tick();
    check("first_valid", out_valid, 1);
    check("first_pc",    out_pc,    32'h8000_0000);
    check("first_count", count_o,   1);
    in_pc = 32'h8000_0004; in_instr = 32'h0020_0113;
    tick();
    check("fill_count",    count_o,   2);
    check("fill_in_ready", in_ready,  0);
    check("fill_head_pc",  out_pc,    32'h8000_0000);
    check("fill_head_ins", out_instr, 32'h0010_0093);

    // Full with push and pop requested: only the pop happens.
    in_pc = 32'h8000_0008; in_instr = 32'h0030_0193; out_ready = 1'b1;
    #1;
    check("full_blocked_ready", in_ready, 0);
    tick();
    check("full_pop_count", count_o,   1);
    check("full_pop_ready", in_ready,  1);
    check("full_pop_pc",    out_pc,    32'h8000_0004);
    check("full_pop_ins",   out_instr, 32'h0020_0113);

    // Streaming push+pop for 10 cycles; pointers wrap repeatedly.
    q_pc.push_back(32'h8000_0004);
    q_instr.push_back(32'h0020_0113);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_pc     = 32'h8000_0008 + 32'(4 * i);
      in_instr  = 32'h0040_0213 + 32'(i);
      #1;
      check("stream_pc",    out_pc,    q_pc[0]);
      check("stream_ins",   out_instr, q_instr[0]);
      check("stream_count", count_o,   1);
      q_pc.push_back(in_pc);
      q_instr.push_back(in_instr);
      void'(q_pc.pop_front());
      void'(q_instr.pop_front());
      tick();
    end
    check("stream_end_pc", out_pc, q_pc[0]);

    // Bring occupancy to two, then flush with an incoming pair.
    out_ready = 1'b0;
    in_pc = 32'h8000_0200; in_instr = 32'h0050_0293;
    tick();
    check("pre_flush_count", count_o, 2);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 32'h8000_0100; in_instr = 32'h0060_0313;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", count_o,   0);
    check("flush_valid", out_valid, 0);
    check("flush_pc",    out_pc,    RST_PC_V);
    check("flush_ins",   out_instr, NOP_V);
    tick();
    check("flush_drop_count", count_o, 0);
    check("flush_drop_pc",    out_pc,  RST_PC_V);

    // Head holds stable while decode stalls.
    in_valid = 1'b1; in_pc = 32'h8000_0300; in_instr = 32'h0070_0393;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc",    out_pc,    32'h8000_0300);
      check("hold_ins",   out_instr, 32'h0070_0393);
      check("hold_count", count_o,   1);
    end

    // Asynchronous reset mid-cycle with a pending pop and push.
    in_valid = 1'b1; in_pc = 32'h8000_0400; in_instr = 32'h0080_0413; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_count", count_o,   0);
    check("async_pc",    out_pc,    RST_PC_V);
    check("async_ins",   out_instr, NOP_V);
    check("async_ready", in_ready,  1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_count", count_o,   0);
    check("post_rst_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
